// File: rtl/temp_entry_classifier.sv
// Debounced key-driven sign + N_DIGITS BCD entry, converted to a signed tenths value and
// classified into a one-hot temperature level. Define TEMP_ENTRY_HYST_EN for falling hysteresis.
module temp_entry_classifier #(
    parameter int N_DIGITS   = 3,
    parameter int VAL_W      = 14,
    parameter int DEB_CYCLES = 250000,
    parameter int T_BORDER   = 380,
    parameter int T_WARN     = 400,
    parameter int T_EMERG    = 420,
    parameter int HYST       = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enter_n,
    input  logic                    clr,
    input  logic                    sign_in,
    input  logic [3:0]              digit_in,
    output logic [2:0]              entry_pos,
    output logic [4*N_DIGITS-1:0]   bcd_digits,
    output logic                    sign_out,
    output logic [VAL_W:0]          value,
    output logic                    value_valid,
    output logic                    entry_err,
    output logic                    normal,
    output logic                    border_line,
    output logic                    warning,
    output logic                    emergency
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // One spare bit over value so that value+HYST can never wrap during the compare.
    localparam int CMP_W = VAL_W + 2;
    localparam logic signed [CMP_W-1:0] T_BORDER_S = CMP_W'(T_BORDER);
    localparam logic signed [CMP_W-1:0] T_WARN_S   = CMP_W'(T_WARN);
    localparam logic signed [CMP_W-1:0] T_EMERG_S  = CMP_W'(T_EMERG);
    localparam logic [2:0]              LAST_POS   = 3'(N_DIGITS);

    typedef enum logic [1:0] {ST_SIGN, ST_DIGITS, ST_CLASSIFY} state_t;
    typedef enum logic [1:0] {
        LVL_NORMAL = 2'd0,
        LVL_BORDER = 2'd1,
        LVL_WARN   = 2'd2,
        LVL_EMERG  = 2'd3
    } level_t;

    state_t                   state;
    level_t                   level_q;
    level_t                   level_next;
    logic [VAL_W-1:0]         acc;
    logic [VAL_W-1:0]         acc_next;
    logic signed [CMP_W-1:0]  val_next;
    logic                     key_meta;
    logic                     key_sync;
    logic [DEB_W-1:0]         deb_cnt;
    logic                     enter_pulse;

    function automatic level_t raw_level(input logic signed [CMP_W-1:0] v);
        if (v >= T_EMERG_S)       return LVL_EMERG;
        else if (v >= T_WARN_S)   return LVL_WARN;
        else if (v >= T_BORDER_S) return LVL_BORDER;
        else                      return LVL_NORMAL;
    endfunction

    // Synchroniser idles high (key released) so reset never looks like a press.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= enter_n;
            key_sync <= key_meta;
        end
    end

    // Counter saturates at DEB_CYCLES while held, so one press gives exactly one pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt     <= '0;
            enter_pulse <= 1'b0;
        end else begin
            enter_pulse <= 1'b0;
            if (key_sync) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_MAX) begin
                deb_cnt <= deb_cnt + 1'b1;
                if (deb_cnt == DEB_LAST) enter_pulse <= 1'b1;
            end
        end
    end

    assign acc_next = acc * VAL_W'(10) + VAL_W'(digit_in);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        level_t raw_now;
        val_next   = sign_out ? -$signed({2'b00, acc}) : $signed({2'b00, acc});
        raw_now    = raw_level(val_next);
        level_next = raw_now;
`ifdef TEMP_ENTRY_HYST_EN
        if (raw_now < level_q) begin
            level_t raw_hyst;
            raw_hyst   = raw_level(val_next + CMP_W'(HYST));
            level_next = (raw_hyst < level_q) ? raw_hyst : level_q;
        end
`endif
        if (val_next[CMP_W-1]) level_next = LVL_NORMAL;
    end

`ifndef TEMP_ENTRY_HYST_EN
    wire unused_hyst = |HYST;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_SIGN;
            entry_pos   <= '0;
            bcd_digits  <= '0;
            sign_out    <= 1'b0;
            acc         <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            entry_err   <= 1'b0;
            level_q     <= LVL_NORMAL;
        end else begin
            entry_err <= 1'b0;
            if (clr) begin
                state       <= ST_SIGN;
                entry_pos   <= '0;
                bcd_digits  <= '0;
                value_valid <= 1'b0;
            end else begin
                case (state)
                    ST_SIGN: if (enter_pulse) begin
                        sign_out    <= sign_in;
                        acc         <= '0;
                        value_valid <= 1'b0;
                        entry_pos   <= 3'd1;
                        state       <= ST_DIGITS;
                    end
                    ST_DIGITS: if (enter_pulse) begin
                        if (digit_in > 4'd9) begin
                            entry_err <= 1'b1;
                        end else begin
                            // Position 1 (MSD) lands in the top nibble.
                            for (int k = 0; k < N_DIGITS; k++)
                                if (entry_pos == 3'(N_DIGITS - k))
                                    bcd_digits[4*k +: 4] <= digit_in;
                            acc       <= acc_next;
                            entry_pos <= entry_pos + 3'd1;
                            if (entry_pos == LAST_POS) state <= ST_CLASSIFY;
                        end
                    end
                    ST_CLASSIFY: begin
                        value       <= val_next[VAL_W:0];
                        if (acc == '0) sign_out <= 1'b0;
                        level_q     <= level_next;
                        value_valid <= 1'b1;
                        entry_pos   <= '0;
                        state       <= ST_SIGN;
                    end
                    default: state <= ST_SIGN;
                endcase
            end
        end
    end

    assign normal      = (level_q == LVL_NORMAL);
    assign border_line = (level_q == LVL_BORDER);
    assign warning     = (level_q == LVL_WARN);
    assign emergency   = (level_q == LVL_EMERG);

endmodule
